oflow_pe_sequencer: RTL and testbench

OFLOW_PE_SEQUENCER -- requirements
Module: oflow_pe_sequencer

---
 rtl/oflow_pe_sequencer.sv | 137 +++++++++++++
 tb/tb_oflow_pe_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/oflow_pe_sequencer.sv
// Frame sequencer for the optical-flow processing element.
// Each set of a frame runs feature extraction, then registration.
// A per-phase watchdog aborts a stalled frame and raises a sticky error.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for start_frame
// FE_RUN  | feature extraction of set set_idx in progress
// REG_RUN | registration of set set_idx in progress
// DONE    | single cycle; done_pe high, then back to IDLE
module oflow_pe_sequencer #(
    parameter int SET_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start_frame,
    input  logic [SET_LEN-1:0] num_of_sets,
    input  logic               done_fe,
    input  logic               done_registration,
    input  logic               clear_err,
    output logic               start_fe,
    output logic               start_registration,
    output logic               done_pe,
    output logic [SET_LEN-1:0] set_idx,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FE_RUN  = 2'd1,
        REG_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0]        WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_LEN-1:0] IDX_ONE   = SET_LEN'(1);

    state_t             state, state_nxt;
    logic [SET_LEN-1:0] num_sets_q, num_sets_nxt;
    logic [SET_LEN-1:0] set_idx_nxt;
    logic [15:0]        wdog_cnt, wdog_nxt;
    logic               start_fe_nxt, start_reg_nxt, done_pe_nxt, timeout_err_nxt;
    logic               wdog_expired, last_set;

    assign wdog_expired = (wdog_cnt == WDOG_LAST);
    assign last_set     = (set_idx == (num_sets_q - IDX_ONE));
    assign busy         = (state != IDLE);

    // State, counters and registered output pulses
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state              <= IDLE;
            num_sets_q         <= '0;
            set_idx            <= '0;
            wdog_cnt           <= '0;
            start_fe           <= 1'b0;
            start_registration <= 1'b0;
            done_pe            <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state              <= state_nxt;
            num_sets_q         <= num_sets_nxt;
            set_idx            <= set_idx_nxt;
            wdog_cnt           <= wdog_nxt;
            start_fe           <= start_fe_nxt;
            start_registration <= start_reg_nxt;
            done_pe            <= done_pe_nxt;
            timeout_err        <= timeout_err_nxt;
        end
    end

    // Next-state, watchdog and pulse decode; a qualifying done beats expiry,
    // and a timeout beats clear_err
    always_comb begin
        state_nxt       = state;
        num_sets_nxt    = num_sets_q;
        set_idx_nxt     = set_idx;
        wdog_nxt        = '0;
        start_fe_nxt    = 1'b0;
        start_reg_nxt   = 1'b0;
        done_pe_nxt     = 1'b0;
        timeout_err_nxt = clear_err ? 1'b0 : timeout_err;

        unique case (state)
            IDLE: begin
                if (start_frame) begin
                    num_sets_nxt = num_of_sets;
                    set_idx_nxt  = '0;
                    if (num_of_sets != '0) begin
                        state_nxt    = FE_RUN;
                        start_fe_nxt = 1'b1;
                    end else begin
                        state_nxt   = DONE;
                        done_pe_nxt = 1'b1;
                    end
                end
            end
            FE_RUN: begin
                if (done_fe) begin
                    state_nxt     = REG_RUN;
                    start_reg_nxt = 1'b1;
                end else if (wdog_expired) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                end else begin
                    wdog_nxt = wdog_cnt + 16'd1;
                end
            end
            REG_RUN: begin
                if (done_registration) begin
                    if (last_set) begin
                        state_nxt   = DONE;
                        done_pe_nxt = 1'b1;
                    end else begin
                        state_nxt    = FE_RUN;
                        set_idx_nxt  = set_idx + IDX_ONE;
                        start_fe_nxt = 1'b1;
                    end
                end else if (wdog_expired) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                end else begin
                    wdog_nxt = wdog_cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oflow_pe_sequencer.sv
// Directed bench for oflow_pe_sequencer: a cycle-by-cycle vector table
// followed by hand-written watchdog, error-clear and reset sequences.
module tb_oflow_pe_sequencer;

    localparam int SL = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_N;
    logic          start_frame;
    logic [SL-1:0] num_of_sets;
    logic          done_fe;
    logic          done_registration;
    logic          clear_err;
    logic          start_fe;
    logic          start_registration;
    logic          done_pe;
    logic [SL-1:0] set_idx;
    logic          busy;
    logic          timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic          sf;
        logic [SL-1:0] n;
        logic          dfe;
        logic          dreg;
        logic          clr;
        logic          e_sfe;
        logic          e_sreg;
        logic          e_dp;
        logic [SL-1:0] e_idx;
        logic          e_busy;
        logic          e_to;
    } vec_t;

    vec_t tbl[$];

    oflow_pe_sequencer #(.SET_LEN(SL), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset_N           (reset_N),
        .start_frame       (start_frame),
        .num_of_sets       (num_of_sets),
        .done_fe           (done_fe),
        .done_registration (done_registration),
        .clear_err         (clear_err),
        .start_fe          (start_fe),
        .start_registration(start_registration),
        .done_pe           (done_pe),
        .set_idx           (set_idx),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sf, input int n, input logic dfe,
                                input logic dreg, input logic clr,
                                input logic sfe, input logic sreg, input logic dp,
                                input int idx, input logic bsy, input logic to);
        vec_t v;
        v.sf = sf;  v.n = SL'(n);  v.dfe = dfe;  v.dreg = dreg;  v.clr = clr;
        v.e_sfe = sfe;  v.e_sreg = sreg;  v.e_dp = dp;  v.e_idx = SL'(idx);
        v.e_busy = bsy;  v.e_to = to;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " start_fe"}, int'(start_fe), int'(v.e_sfe));
        chk({tag, " start_registration"}, int'(start_registration), int'(v.e_sreg));
        chk({tag, " done_pe"}, int'(done_pe), int'(v.e_dp));
        chk({tag, " set_idx"}, int'(set_idx), int'(v.e_idx));
        chk({tag, " busy"}, int'(busy), int'(v.e_busy));
        chk({tag, " timeout_err"}, int'(timeout_err), int'(v.e_to));
    endtask

    // Drive one cycle of inputs, clock once, check the registered result.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        start_frame       = v.sf;
        num_of_sets       = v.n;
        done_fe           = v.dfe;
        done_registration = v.dreg;
        clear_err         = v.clr;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    task automatic idle_steps(input string tag, input int cnt, input int idx,
                              input logic bsy, input logic to);
        for (int k = 0; k < cnt; k++)
            step(tag, mk(0, 0, 0, 0, 0, 0, 0, 0, idx, bsy, to));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_N = 1'b0;  start_frame = 1'b0;  num_of_sets = '0;
        done_fe = 1'b0;  done_registration = 1'b0;  clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_N = 1'b1;

        // 3-set frame, each done returned 2 cycles after its start pulse
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        // zero-set frame goes straight to DONE
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 2-set frame with stray start_frame / done pulses in the wrong states
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // watchdog: done_fe never returns, error 16 cycles after start_fe
        step("to_start", mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        idle_steps("to_wait", TO - 1, 0, 1'b1, 1'b0);
        step("to_fire", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // error does not block a new frame; timeout beats simultaneous clear
        step("err_start", mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        idle_steps("err_wait", TO - 1, 0, 1'b1, 1'b1);
        step("err_prio", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        step("err_clear", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // done coincident with expiry wins in both phases
        step("co_start", mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        idle_steps("co_fe_wait", TO - 1, 0, 1'b1, 1'b0);
        step("co_fe_done", mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        idle_steps("co_reg_wait", TO - 1, 0, 1'b1, 1'b0);
        step("co_reg_done", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        step("co_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset during REG_RUN of set 1, then a clean 1-set frame
        step("rs_start", mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        step("rs_fe0", mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        step("rs_reg0", mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0));
        step("rs_fe1", mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        #1;
        reset_N = 1'b0;
        #1;
        check_outs("rs_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_outs("rs_held", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_N = 1'b1;
        step("pr_start", mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        step("pr_fe", mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        step("pr_reg", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        step("pr_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
